// File: rtl/input_conditioner.sv
// input_conditioner
// Two-flop synchronizers followed by counter-based debouncers for the
// switch bus and the active-low execute button. Produces a stable switch
// word with a one-cycle change strobe, plus a debounced button level and a
// single-cycle exec pulse per clean press.

module input_conditioner #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_inp,
    input  logic             raw_exec_n,
    output logic [WIDTH-1:0] inp_clean,
    output logic             inp_changed,
    output logic             exec_level,
    output logic             exec
);

    // Count value at which a candidate has been stable long enough.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // Synchronizer stages
    logic [WIDTH-1:0] inp_s1_r;
    logic [WIDTH-1:0] inp_s2_r;
    logic             btn_s1_r;
    logic             btn_s2_r;

    // Switch debouncer state
    logic [WIDTH-1:0] inp_cand_r;
    logic [CNT_W-1:0] inp_cnt_r;

    // Button debouncer state (candidate holds the pressed level, 1 = pressed)
    logic             btn_cand_r;
    logic [CNT_W-1:0] btn_cnt_r;

    // Next-state signals
    logic [WIDTH-1:0] inp_cand_next_s;
    logic [CNT_W-1:0] inp_cnt_next_s;
    logic [WIDTH-1:0] inp_clean_next_s;
    logic             inp_changed_next_s;
    logic             btn_pressed_s;
    logic             btn_cand_next_s;
    logic [CNT_W-1:0] btn_cnt_next_s;
    logic             exec_level_next_s;
    logic             exec_next_s;

    // Two-flop synchronizers; the button path idles released (high).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inp_s1_r <= {WIDTH{1'b0}};
            inp_s2_r <= {WIDTH{1'b0}};
            btn_s1_r <= 1'b1;
            btn_s2_r <= 1'b1;
        end else begin
            inp_s1_r <= raw_inp;
            inp_s2_r <= inp_s1_r;
            btn_s1_r <= raw_exec_n;
            btn_s2_r <= btn_s1_r;
        end
    end

    // Switch debounce: restart on any change, accept once the count saturates.
    always_comb begin
        inp_cand_next_s  = inp_cand_r;
        inp_cnt_next_s   = inp_cnt_r;
        inp_clean_next_s = inp_clean;
        if (inp_s2_r != inp_cand_r) begin
            inp_cand_next_s = inp_s2_r;
            inp_cnt_next_s  = {CNT_W{1'b0}};
        end else if (inp_cnt_r == CNT_MAX) begin
            inp_clean_next_s = inp_cand_r;
        end else begin
            inp_cnt_next_s = inp_cnt_r + CNT_W'(1);
        end
        // Strobe only when the accepted word really differs.
        inp_changed_next_s = (inp_clean_next_s != inp_clean);
    end

    // Button debounce on the pressed (inverted) level, same rules as the switches.
    always_comb begin
        btn_pressed_s     = ~btn_s2_r;
        btn_cand_next_s   = btn_cand_r;
        btn_cnt_next_s    = btn_cnt_r;
        exec_level_next_s = exec_level;
        if (btn_pressed_s != btn_cand_r) begin
            btn_cand_next_s = btn_pressed_s;
            btn_cnt_next_s  = {CNT_W{1'b0}};
        end else if (btn_cnt_r == CNT_MAX) begin
            exec_level_next_s = btn_cand_r;
        end else begin
            btn_cnt_next_s = btn_cnt_r + CNT_W'(1);
        end
        // Rising edge of the debounced level, aligned with exec_level itself.
        exec_next_s = exec_level_next_s & ~exec_level;
    end

    // Debouncer state and registered outputs; reset discards any pending debounce.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inp_cand_r  <= {WIDTH{1'b0}};
            inp_cnt_r   <= {CNT_W{1'b0}};
            inp_clean   <= {WIDTH{1'b0}};
            inp_changed <= 1'b0;
            btn_cand_r  <= 1'b0;
            btn_cnt_r   <= {CNT_W{1'b0}};
            exec_level  <= 1'b0;
            exec        <= 1'b0;
        end else begin
            inp_cand_r  <= inp_cand_next_s;
            inp_cnt_r   <= inp_cnt_next_s;
            inp_clean   <= inp_clean_next_s;
            inp_changed <= inp_changed_next_s;
            btn_cand_r  <= btn_cand_next_s;
            btn_cnt_r   <= btn_cnt_next_s;
            exec_level  <= exec_level_next_s;
            exec        <= exec_next_s;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with STABLE_CYCLES = 4.
// A run-length reference model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations around them.

module tb_input_conditioner;

    localparam int WIDTH  = 16;
    localparam int STABLE = 4;
    localparam int CNT_W  = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] raw_inp = 16'h0000;
    logic             raw_exec_n = 1'b1;
    logic [WIDTH-1:0] inp_clean;
    logic             inp_changed;
    logic             exec_level;
    logic             exec;

    int checks = 0;
    int errors = 0;

    input_conditioner #(
        .WIDTH(WIDTH),
        .STABLE_CYCLES(STABLE),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .raw_inp(raw_inp),
        .raw_exec_n(raw_exec_n),
        .inp_clean(inp_clean),
        .inp_changed(inp_changed),
        .exec_level(exec_level),
        .exec(exec)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Synchronizer delay as a two-deep history; debounce as "value seen in
    // the synchronized stream for at least STABLE+1 consecutive edges".
    logic [WIDTH-1:0] m_h1 = 16'h0000, m_h2 = 16'h0000;
    logic             b_h1 = 1'b1, b_h2 = 1'b1;
    logic [WIDTH-1:0] run_val = 16'h0000;
    int               run_len = 1;
    logic             brun_val = 1'b0;
    int               brun_len = 1;
    logic [WIDTH-1:0] m_clean = 16'h0000;
    logic             m_changed = 1'b0;
    logic             m_level = 1'b0;
    logic             m_exec = 1'b0;

    task automatic model_step();
        logic [WIDTH-1:0] nc;
        logic             nl;
        if (reset) begin
            m_h1 = 16'h0000; m_h2 = 16'h0000; b_h1 = 1'b1; b_h2 = 1'b1;
            run_val = 16'h0000; run_len = 1; brun_val = 1'b0; brun_len = 1;
            m_clean = 16'h0000; m_changed = 1'b0; m_level = 1'b0; m_exec = 1'b0;
        end else begin
            if (m_h2 == run_val) begin
                if (run_len < 1000) run_len++;
            end else begin
                run_val = m_h2; run_len = 1;
            end
            nc = (run_len >= STABLE + 1) ? run_val : m_clean;
            m_changed = (nc != m_clean);
            m_clean = nc;
            if (!b_h2 == brun_val) begin
                if (brun_len < 1000) brun_len++;
            end else begin
                brun_val = !b_h2; brun_len = 1;
            end
            nl = (brun_len >= STABLE + 1) ? brun_val : m_level;
            m_exec = nl && !m_level;
            m_level = nl;
            m_h2 = m_h1; m_h1 = raw_inp;
            b_h2 = b_h1; b_h1 = raw_exec_n;
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    initial forever begin
        @(negedge clock);
        chk("model_inp_clean", 32'(inp_clean), 32'(m_clean));
        chk("model_inp_changed", 32'(inp_changed), 32'(m_changed));
        chk("model_exec_level", 32'(exec_level), 32'(m_level));
        chk("model_exec", 32'(exec), 32'(m_exec));
    end

    // Inputs change just after the falling edge, after the compare.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    int strobes;
    int pulses;
    int highs;
    int hold_i;
    int hold_b;

    initial begin
        // ---- reset with active inputs ----
        raw_inp = 16'hFFFF; raw_exec_n = 1'b0; reset = 1'b1;
        repeat (3) tick();
        chk("rst_inp_clean", 32'(inp_clean), 32'h0);
        chk("rst_inp_changed", 32'(inp_changed), 32'h0);
        chk("rst_exec_level", 32'(exec_level), 32'h0);
        chk("rst_exec", 32'(exec), 32'h0);
        reset = 1'b0;
        repeat (6) tick();
        chk("rel_edge6_clean", 32'(inp_clean), 32'h0);
        chk("rel_edge6_exec", 32'(exec), 32'h0);
        tick();
        chk("rel_edge7_clean", 32'(inp_clean), 32'hFFFF);
        chk("rel_edge7_exec", 32'(exec), 32'h1);
        chk("rel_edge7_changed", 32'(inp_changed), 32'h1);
        tick();
        chk("rel_edge8_exec", 32'(exec), 32'h0);
        chk("rel_edge8_changed", 32'(inp_changed), 32'h0);
        chk("rel_edge8_level", 32'(exec_level), 32'h1);

        // ---- clean switch change ----
        reset = 1'b1; raw_inp = 16'h0000; raw_exec_n = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        raw_inp = 16'h1234;
        repeat (6) tick();
        chk("clean_edge6", 32'(inp_clean), 32'h0);
        tick();
        chk("clean_edge7", 32'(inp_clean), 32'h1234);
        chk("clean_strobe", 32'(inp_changed), 32'h1);
        strobes = 0;
        repeat (20) begin tick(); if (inp_changed) strobes++; end
        chk("clean_no_more_strobes", 32'(strobes), 32'h0);

        // ---- switch bounce ----
        raw_inp = 16'h0000;
        repeat (15) tick();
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            raw_inp = (((i / 2) % 2) == 0) ? 16'h0001 : 16'h0000;
            tick();
            if (inp_changed) strobes++;
            chk("bounce_hold0", 32'(inp_clean), 32'h0);
        end
        // Last change was driven two ticks ago.
        repeat (4) begin tick(); if (inp_changed) strobes++; end
        chk("bounce_settle_early", 32'(inp_clean), 32'h0);
        tick(); if (inp_changed) strobes++;
        chk("bounce_settle", 32'(inp_clean), 32'h0001);
        repeat (10) begin tick(); if (inp_changed) strobes++; end
        chk("bounce_one_strobe", 32'(strobes), 32'h1);

        // ---- press and hold ----
        pulses = 0;
        raw_exec_n = 1'b0;
        repeat (50) begin tick(); if (exec) pulses++; end
        chk("hold_level", 32'(exec_level), 32'h1);
        raw_exec_n = 1'b1;
        repeat (6) begin tick(); if (exec) pulses++; end
        chk("release_level_still1", 32'(exec_level), 32'h1);
        tick();
        chk("release_level0", 32'(exec_level), 32'h0);
        chk("hold_one_pulse", 32'(pulses), 32'h1);

        // ---- short glitch ----
        pulses = 0; highs = 0;
        raw_exec_n = 1'b0;
        repeat (3) begin tick(); if (exec) pulses++; if (exec_level) highs++; end
        raw_exec_n = 1'b1;
        repeat (20) begin tick(); if (exec) pulses++; if (exec_level) highs++; end
        chk("glitch_no_exec", 32'(pulses), 32'h0);
        chk("glitch_no_level", 32'(highs), 32'h0);

        // ---- reset mid-debounce ----
        raw_inp = 16'h00A5;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("async_clear_clean", 32'(inp_clean), 32'h0);
        chk("async_clear_changed", 32'(inp_changed), 32'h0);
        tick();
        reset = 1'b0;
        strobes = 0;
        repeat (6) begin tick(); if (inp_changed) strobes++; end
        chk("mid_rst_clean0", 32'(inp_clean), 32'h0);
        chk("mid_rst_no_strobe", 32'(strobes), 32'h0);
        tick();
        chk("mid_rst_restart", 32'(inp_clean), 32'h00A5);

        // ---- randomized traffic ----
        hold_i = 0; hold_b = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold_i == 0) begin
                if ($urandom_range(3, 0) == 0) raw_inp = 16'($urandom);
                else raw_inp = raw_inp ^ (16'h0001 << $urandom_range(15, 0));
                hold_i = $urandom_range(12, 1);
            end
            if (hold_b == 0) begin
                raw_exec_n = ~raw_exec_n;
                hold_b = $urandom_range(14, 1);
            end
            reset = ($urandom_range(199, 0) == 0);
            hold_i--; hold_b--;
            tick();
        end
        reset = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
